// File: rtl/raymarch_scheduler.sv
// raymarch_scheduler: raster-order dispatcher for a bank of raymarch cores,
// collecting finished colours into a single-entry frame-buffer write register.
module raymarch_scheduler #(
    parameter int WIDTH = 1280,
    parameter int HEIGHT = 720,
    parameter int NUM_CORES = 4,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH * HEIGHT)
) (
    input  logic                    clk_pixel_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    output logic                    busy_out,
    output logic                    frame_done_out,
    output logic [NUM_CORES-1:0]    core_start_out,
    output logic [NUM_CORES*XW-1:0] core_x_out,
    output logic [NUM_CORES*YW-1:0] core_y_out,
    input  logic [NUM_CORES-1:0]    core_done_in,
    input  logic [NUM_CORES*24-1:0] core_rgb_in,
    output logic [AW-1:0]           fb_addr_out,
    output logic [23:0]             fb_data_out,
    output logic                    fb_valid_out,
    input  logic                    fb_ready_in
);
    localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    // C_OUT: result sits in the output register, core not reusable until accepted
    typedef enum logic [1:0] {C_FREE, C_BUSY, C_PEND, C_OUT} core_t;

    state_t                  state_q, state_d;
    core_t                   st_q [NUM_CORES];
    core_t                   st_d [NUM_CORES];
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [XW-1:0]           tag_x_q [NUM_CORES];
    logic [XW-1:0]           tag_x_d [NUM_CORES];
    logic [YW-1:0]           tag_y_q [NUM_CORES];
    logic [YW-1:0]           tag_y_d [NUM_CORES];
    logic [23:0]             res_q [NUM_CORES];
    logic [23:0]             res_d [NUM_CORES];
    logic [NUM_CORES-1:0]    core_start_q, core_start_d;
    logic [NUM_CORES*XW-1:0] core_x_q, core_x_d;
    logic [NUM_CORES*YW-1:0] core_y_q, core_y_d;
    logic [AW-1:0]           fb_addr_q, fb_addr_d;
    logic [23:0]             fb_data_q, fb_data_d;
    logic                    fb_valid_q, fb_valid_d;
    logic [IW-1:0]           out_idx_q, out_idx_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    accept, free_found, pend_found, all_free, last_x, last_y;
    logic [IW-1:0]           free_idx, pend_idx;

    assign busy_out       = busy_q;
    assign frame_done_out = done_q;
    assign core_start_out = core_start_q;
    assign core_x_out     = core_x_q;
    assign core_y_out     = core_y_q;
    assign fb_addr_out    = fb_addr_q;
    assign fb_data_out    = fb_data_q;
    assign fb_valid_out   = fb_valid_q;

    assign accept = fb_valid_q && fb_ready_in;
    assign last_x = x_q == XW'(WIDTH - 1);
    assign last_y = y_q == YW'(HEIGHT - 1);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        pend_found = 1'b0;
        pend_idx   = '0;
        all_free   = 1'b1;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (st_q[i] == C_FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            all_free = all_free & (st_q[i] == C_FREE);
        end
        // scanning downwards leaves the first PENDING core at or after rr_q
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (st_q[IW'((int'(rr_q) + k) % NUM_CORES)] == C_PEND) begin
                pend_found = 1'b1;
                pend_idx   = IW'((int'(rr_q) + k) % NUM_CORES);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        st_d         = st_q;
        tag_x_d      = tag_x_q;
        tag_y_d      = tag_y_q;
        res_d        = res_q;
        core_start_d = '0;
        core_x_d     = core_x_q;
        core_y_d     = core_y_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        fb_valid_d   = fb_valid_q;
        out_idx_d    = out_idx_q;
        rr_d         = rr_q;
        done_d       = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_done_in[i] && st_q[i] == C_BUSY) begin
                st_d[i]  = C_PEND;
                res_d[i] = core_rgb_in[i*24 +: 24];
            end
        end
        if (accept) begin
            st_d[out_idx_q] = C_FREE;
            fb_valid_d      = 1'b0;
        end
        if ((!fb_valid_q || accept) && pend_found) begin
            st_d[pend_idx] = C_OUT;
            out_idx_d      = pend_idx;
            fb_valid_d     = 1'b1;
            fb_addr_d      = AW'(tag_y_q[pend_idx]) * AW'(WIDTH) + AW'(tag_x_q[pend_idx]);
            fb_data_d      = res_q[pend_idx];
            rr_d           = (int'(pend_idx) == NUM_CORES - 1) ? '0 : pend_idx + IW'(1);
        end
        if (state_q == S_IDLE && start_in) begin
            state_d = S_RUN;
        end
        if (state_q == S_RUN && free_found) begin
            core_start_d[free_idx]                 = 1'b1;
            core_x_d[int'(free_idx)*XW +: XW]      = x_q;
            core_y_d[int'(free_idx)*YW +: YW]      = y_q;
            tag_x_d[free_idx]                      = x_q;
            tag_y_d[free_idx]                      = y_q;
            st_d[free_idx]                         = C_BUSY;
            x_d     = last_x ? '0 : x_q + XW'(1);
            y_d     = last_x ? (last_y ? '0 : y_q + YW'(1)) : y_q;
            state_d = (last_x && last_y) ? S_DRAIN : S_RUN;
        end
        if (state_q == S_DRAIN && all_free && !fb_valid_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            st_q         <= '{default: C_FREE};
            tag_x_q      <= '{default: '0};
            tag_y_q      <= '{default: '0};
            res_q        <= '{default: '0};
            core_start_q <= '0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_valid_q   <= 1'b0;
            out_idx_q    <= '0;
            rr_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            st_q         <= st_d;
            tag_x_q      <= tag_x_d;
            tag_y_q      <= tag_y_d;
            res_q        <= res_d;
            core_start_q <= core_start_d;
            core_x_q     <= core_x_d;
            core_y_q     <= core_y_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_valid_q   <= fb_valid_d;
            out_idx_q    <= out_idx_d;
            rr_q         <= rr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end
endmodule
